// File: rtl/csram_bank_arbiter_if.sv
// Requester-side and bank-side signal bundle for csram_bank_arbiter.
// The slave modport is the arbiter; the master modport is everything around it (requesters and SRAM banks).
interface csram_bank_arbiter_if #(
    parameter int unsigned BANK_AW = 10
);
    localparam int unsigned AW = BANK_AW + 2;

    logic [2:0]           req_i;
    logic [2:0]           req_we_i;
    logic [3*AW-1:0]      req_addr_i;
    logic [95:0]          req_wdata_i;
    logic [11:0]          req_wstrb_i;
    logic [2:0]           req_gnt_o;
    logic [2:0]           rsp_valid_o;
    logic [95:0]          rsp_rdata_o;
    logic [3:0]           bank_cs_o;
    logic [15:0]          bank_wen_o;
    logic [4*BANK_AW-1:0] bank_addr_o;
    logic [127:0]         bank_wdata_o;
    logic [127:0]         bank_rdata_i;

    modport master (
        output req_i, req_we_i, req_addr_i, req_wdata_i, req_wstrb_i, bank_rdata_i,
        input  req_gnt_o, rsp_valid_o, rsp_rdata_o,
        input  bank_cs_o, bank_wen_o, bank_addr_o, bank_wdata_o
    );

    modport slave (
        input  req_i, req_we_i, req_addr_i, req_wdata_i, req_wstrb_i, bank_rdata_i,
        output req_gnt_o, rsp_valid_o, rsp_rdata_o,
        output bank_cs_o, bank_wen_o, bank_addr_o, bank_wdata_o
    );
endinterface

// File: rtl/csram_bank_arbiter.sv
// Per-bank arbiter sharing four 32-bit CSRAM banks among debug (0), DMA write (1) and DMA read (2),
// with starvation override for the DMA requesters and fixed one-cycle read-data return.
module csram_bank_arbiter #(
    parameter int unsigned BANK_AW      = 10,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input logic                 clk_i,
    input logic                 rst_i,
    csram_bank_arbiter_if.slave bus
);
    localparam int unsigned AW = BANK_AW + 2;

    logic [1:0] req_bank   [3];
    logic [2:0] hit        [4];
    logic [1:0] starve_hit [4];
    logic [1:0] win        [4];
    logic [3:0] win_vld;
    logic [2:0] gnt;
    logic [3:0] rr;
    logic [7:0] starve_cnt [2];
    logic [1:0] starving;
    logic [2:0] rsp_valid;
    logic [1:0] rsp_bank   [3];

    always_comb begin
        for (int unsigned i = 0; i < 3; i++) begin
            req_bank[i] = bus.req_addr_i[i*AW+BANK_AW +: 2];
        end
        for (int unsigned i = 0; i < 2; i++) begin
            starving[i] = (starve_cnt[i] == 8'(STARVE_LIMIT));
        end
    end

    // rr[b]=0 favours requester 1, rr[b]=1 favours requester 2.
    always_comb begin
        gnt     = '0;
        win_vld = '0;
        for (int unsigned b = 0; b < 4; b++) begin
            win[b] = '0;
            for (int unsigned i = 0; i < 3; i++) begin
                hit[b][i] = bus.req_i[i] && (req_bank[i] == 2'(b));
            end
            starve_hit[b] = {hit[b][2] & starving[1], hit[b][1] & starving[0]};
            if (starve_hit[b] == 2'b11)
                win[b] = rr[b] ? 2'd2 : 2'd1;
            else if (starve_hit[b][0])
                win[b] = 2'd1;
            else if (starve_hit[b][1])
                win[b] = 2'd2;
            else if (hit[b][0])
                win[b] = 2'd0;
            else if (hit[b][1] && hit[b][2])
                win[b] = rr[b] ? 2'd2 : 2'd1;
            else if (hit[b][1])
                win[b] = 2'd1;
            else
                win[b] = 2'd2;
            win_vld[b] = |hit[b];
            if (win_vld[b])
                gnt[win[b]] = 1'b1;
        end
    end

    always_comb begin
        bus.req_gnt_o    = gnt;
        bus.bank_cs_o    = '0;
        bus.bank_wen_o   = '0;
        bus.bank_addr_o  = '0;
        bus.bank_wdata_o = '0;
        for (int unsigned b = 0; b < 4; b++) begin
            if (win_vld[b]) begin
                bus.bank_cs_o[b]                   = 1'b1;
                bus.bank_addr_o[b*BANK_AW +: BANK_AW] = bus.req_addr_i[int'(win[b])*AW +: BANK_AW];
                bus.bank_wdata_o[b*32 +: 32]       = bus.req_wdata_i[int'(win[b])*32 +: 32];
                bus.bank_wen_o[b*4 +: 4]           = bus.req_we_i[win[b]] ?
                                                     bus.req_wstrb_i[int'(win[b])*4 +: 4] : 4'b0000;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr         <= '0;
            rsp_valid  <= '0;
            for (int unsigned i = 0; i < 2; i++) starve_cnt[i] <= '0;
            for (int unsigned i = 0; i < 3; i++) rsp_bank[i]   <= '0;
        end else begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (win_vld[b] && win[b] != 2'd0)
                    rr[b] <= (win[b] == 2'd1);
            end
            for (int unsigned i = 0; i < 2; i++) begin
                if (!bus.req_i[i+1] || gnt[i+1])
                    starve_cnt[i] <= '0;
                else if (!starving[i])
                    starve_cnt[i] <= starve_cnt[i] + 8'd1;
            end
            rsp_valid <= gnt & ~bus.req_we_i;
            for (int unsigned i = 0; i < 3; i++) rsp_bank[i] <= req_bank[i];
        end
    end

    always_comb begin
        bus.rsp_valid_o = rsp_valid;
        bus.rsp_rdata_o = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            if (rsp_valid[i])
                bus.rsp_rdata_o[i*32 +: 32] = bus.bank_rdata_i[int'(rsp_bank[i])*32 +: 32];
        end
    end
endmodule

// File: tb/tb_csram_bank_arbiter.sv
// Directed bench for csram_bank_arbiter with a four-bank byte-writable SRAM model behind it.
module tb_csram_bank_arbiter;
    localparam int unsigned BANK_AW = 10;
    localparam int unsigned AW      = BANK_AW + 2;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   tests = 0;
    int   fails = 0;

    logic [31:0] mem [4][1 << BANK_AW];

    csram_bank_arbiter_if #(.BANK_AW(BANK_AW)) bus ();

    csram_bank_arbiter #(.BANK_AW(BANK_AW), .STARVE_LIMIT(8)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (bus.bank_cs_o[b]) begin
                bus.bank_rdata_i[b*32 +: 32] <= mem[b][bus.bank_addr_o[b*BANK_AW +: BANK_AW]];
                for (int k = 0; k < 4; k++) begin
                    if (bus.bank_wen_o[b*4+k])
                        mem[b][bus.bank_addr_o[b*BANK_AW +: BANK_AW]][k*8 +: 8] <= bus.bank_wdata_o[b*32+k*8 +: 8];
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int unsigned i, input logic we, input logic [11:0] addr,
                         input logic [31:0] wd, input logic [3:0] st);
        bus.req_i[i]              = 1'b1;
        bus.req_we_i[i]           = we;
        bus.req_addr_i[i*AW +: AW] = addr;
        bus.req_wdata_i[i*32 +: 32] = wd;
        bus.req_wstrb_i[i*4 +: 4]  = st;
    endtask

    task automatic drop(input int unsigned i);
        bus.req_i[i]               = 1'b0;
        bus.req_we_i[i]            = 1'b0;
        bus.req_addr_i[i*AW +: AW] = '0;
        bus.req_wdata_i[i*32 +: 32] = '0;
        bus.req_wstrb_i[i*4 +: 4]  = '0;
    endtask

    initial begin
        bus.req_i        = '0;
        bus.req_we_i     = '0;
        bus.req_addr_i   = '0;
        bus.req_wdata_i  = '0;
        bus.req_wstrb_i  = '0;
        bus.bank_rdata_i = '0;

        // Reset state
        @(negedge clk_i); @(negedge clk_i); #1;
        chk("rst_gnt",   128'(bus.req_gnt_o),   128'h0);
        chk("rst_valid", 128'(bus.rsp_valid_o), 128'h0);
        chk("rst_rdata", 128'(bus.rsp_rdata_o), 128'h0);
        chk("rst_cs",    128'(bus.bank_cs_o),   128'h0);
        chk("rst_wen",   128'(bus.bank_wen_o),  128'h0);
        chk("rst_addr",  128'(bus.bank_addr_o), 128'h0);
        @(negedge clk_i); rst_i = 1'b0;

        // T1: debug beats DMA read on bank 2
        @(negedge clk_i);
        drive(0, 1'b0, 12'h801, 32'h0, 4'h0);
        drive(2, 1'b0, 12'h802, 32'h0, 4'h0);
        #1;
        chk("t1_gnt0",  128'(bus.req_gnt_o),   128'h1);
        chk("t1_cs",    128'(bus.bank_cs_o),   128'h4);
        chk("t1_addr",  128'(bus.bank_addr_o), 128'h0000100000);
        @(negedge clk_i); drop(0); #1;
        chk("t1_gnt2",  128'(bus.req_gnt_o),   128'h4);
        chk("t1_vld0",  128'(bus.rsp_valid_o), 128'h1);
        @(negedge clk_i); drop(2); #1;
        chk("t1_vld2",  128'(bus.rsp_valid_o), 128'h4);
        chk("t1_idle",  128'(bus.req_gnt_o),   128'h0);
        @(negedge clk_i); #1;
        chk("t1_vldoff", 128'(bus.rsp_valid_o), 128'h0);

        // T2: different banks served in the same cycle
        @(negedge clk_i);
        drive(1, 1'b1, 12'h005, 32'h11223344, 4'hF);
        drive(2, 1'b0, 12'h400, 32'h0, 4'h0);
        #1;
        chk("t2_gnt",   128'(bus.req_gnt_o),    128'h6);
        chk("t2_cs",    128'(bus.bank_cs_o),    128'h3);
        chk("t2_wen",   128'(bus.bank_wen_o),   128'h000F);
        chk("t2_wdata", bus.bank_wdata_o,        128'h11223344);
        chk("t2_addr",  128'(bus.bank_addr_o),  128'h5);
        @(negedge clk_i); drop(1); drop(2); #1;
        chk("t2_vld",   128'(bus.rsp_valid_o),  128'h4);

        // T3: DMA write/read alternate on bank 3
        @(negedge clk_i);
        drive(1, 1'b1, 12'hC00, 32'hCAFE0000, 4'hF);
        drive(2, 1'b0, 12'hC01, 32'h0, 4'h0);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("t3_gnt%0d", k), 128'(bus.req_gnt_o), (k % 2 == 0) ? 128'h2 : 128'h4);
            @(negedge clk_i);
        end
        drop(1); drop(2);

        // T4: starvation override against debug on bank 0
        @(negedge clk_i);
        drive(0, 1'b0, 12'h000, 32'h0, 4'h0);
        drive(1, 1'b1, 12'h001, 32'h55AA55AA, 4'hF);
        for (int k = 0; k < 10; k++) begin
            #1;
            chk($sformatf("t4_gnt%0d", k), 128'(bus.req_gnt_o), (k == 8) ? 128'h2 : 128'h1);
            @(negedge clk_i);
        end
        drop(0); drop(1);

        // T5: partial-strobe write then read-back
        @(negedge clk_i);
        drive(1, 1'b1, 12'h805, 32'h12345678, 4'hF); #1;
        chk("t5_gnt_w1", 128'(bus.req_gnt_o),  128'h2);
        chk("t5_wen1",   128'(bus.bank_wen_o), 128'h0F00);
        @(negedge clk_i);
        drive(1, 1'b1, 12'h805, 32'hA5A55A5A, 4'h3); #1;
        chk("t5_wen2",   128'(bus.bank_wen_o), 128'h0300);
        chk("t5_wdata",  bus.bank_wdata_o,     128'hA5A55A5A << 64);
        @(negedge clk_i); drop(1);
        drive(0, 1'b1, 12'h806, 32'hFFFFFFFF, 4'h0); #1;
        chk("t5_zs_gnt", 128'(bus.req_gnt_o),  128'h1);
        chk("t5_zs_cs",  128'(bus.bank_cs_o),  128'h4);
        chk("t5_zs_wen", 128'(bus.bank_wen_o), 128'h0);
        @(negedge clk_i); drop(0);
        drive(2, 1'b0, 12'h805, 32'h0, 4'h0); #1;
        chk("t5_gnt_r",  128'(bus.req_gnt_o),  128'h4);
        chk("t5_wen_r",  128'(bus.bank_wen_o), 128'h0);
        @(negedge clk_i); drop(2); #1;
        chk("t5_vld",    128'(bus.rsp_valid_o), 128'h4);
        chk("t5_rdata",  bus.rsp_rdata_o,       96'h12345A5A << 64);

        // T6: reset right after a read grant drops the response and resets rr
        @(negedge clk_i);
        drive(1, 1'b0, 12'hC00, 32'h0, 4'h0); #1;
        chk("t6_gnt",    128'(bus.req_gnt_o),   128'h2);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        drop(1);
        #1;
        chk("t6_vld_rst", 128'(bus.rsp_valid_o), 128'h0);
        chk("t6_rdata",   128'(bus.rsp_rdata_o), 128'h0);
        @(negedge clk_i); @(negedge clk_i); #1;
        chk("t6_vld_hold", 128'(bus.rsp_valid_o), 128'h0);
        rst_i = 1'b0;
        @(negedge clk_i); #1;
        chk("t6_vld_post", 128'(bus.rsp_valid_o), 128'h0);
        drive(1, 1'b1, 12'hC00, 32'h0, 4'hF);
        drive(2, 1'b0, 12'hC01, 32'h0, 4'h0);
        #1;
        chk("t6_rr", 128'(bus.req_gnt_o), 128'h2);
        @(negedge clk_i); drop(1); drop(2);
        @(negedge clk_i);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
